// File: rtl/bf_pkg.sv
// rtl/bf_pkg.sv - shared op-code constants and loop-controller state encoding
package bf_pkg;

    localparam logic [1:0] OP_OTHER = 2'b00;
    localparam logic [1:0] OP_OPEN  = 2'b01;
    localparam logic [1:0] OP_CLOSE = 2'b10;

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_SKIP  = 2'b01,
        ST_JUMP  = 2'b10,
        ST_ERROR = 2'b11
    } lc_state_t;

endpackage

// File: rtl/loop_ctrl_if.sv
// rtl/loop_ctrl_if.sv - decoded-op handshake between instruction decode and loop_ctrl
interface loop_ctrl_if #(
    parameter int WIDTH = 16
);
    logic             op_valid;
    logic             op_ready;
    logic [1:0]       op_code;
    logic [WIDTH-1:0] op_pc;
    logic             cell_zero;

    modport master (
        output op_valid,
        output op_code,
        output op_pc,
        output cell_zero,
        input  op_ready
    );

    modport slave (
        input  op_valid,
        input  op_code,
        input  op_pc,
        input  cell_zero,
        output op_ready
    );
endinterface

// File: rtl/loop_ctrl.sv
// rtl/loop_ctrl.sv - bracket-matching controller owning the loop-return stack pointer
module loop_ctrl
    import bf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             resetq,
    loop_ctrl_if.slave       op,
    output logic             jump_valid,
    output logic [WIDTH-1:0] jump_pc,
    output logic             skip,
    output logic [DEPTH-1:0] stk_ra,
    input  logic [WIDTH-1:0] stk_rd,
    output logic             stk_we,
    output logic [DEPTH-1:0] stk_wa,
    output logic [WIDTH-1:0] stk_wd,
    output logic [DEPTH:0]   depth,
    output logic             err_overflow,
    output logic             err_underflow
);

    localparam logic [DEPTH:0]   SP_FULL  = {1'b1, {DEPTH{1'b0}}};
    localparam logic [WIDTH-1:0] NEST_MAX = '1;

    lc_state_t        state_q, state_d;
    logic [DEPTH:0]   sp_q, sp_d;
    logic [WIDTH-1:0] nest_q, nest_d;
    logic [WIDTH-1:0] jump_pc_q, jump_pc_d;
    logic             skip_q, skip_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             accept;

    assign op.op_ready = resetq && ((state_q == ST_RUN) || (state_q == ST_SKIP));
    assign accept      = op.op_valid && op.op_ready;

    // Stack read points at the top entry; a push in the previous cycle is already visible.
    assign stk_ra = sp_q[DEPTH-1:0] - DEPTH'(1);
    assign stk_wa = sp_q[DEPTH-1:0];
    assign stk_wd = op.op_pc;

    assign jump_valid    = (state_q == ST_JUMP);
    assign jump_pc       = jump_pc_q;
    assign skip          = skip_q;
    assign depth         = sp_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state_q   <= ST_RUN;
            sp_q      <= '0;
            nest_q    <= '0;
            jump_pc_q <= '0;
            skip_q    <= 1'b0;
            ovf_q     <= 1'b0;
            unf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            nest_q    <= nest_d;
            jump_pc_q <= jump_pc_d;
            skip_q    <= skip_d;
            ovf_q     <= ovf_d;
            unf_q     <= unf_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sp_d      = sp_q;
        nest_d    = nest_q;
        jump_pc_d = jump_pc_q;
        ovf_d     = ovf_q;
        unf_d     = unf_q;
        stk_we    = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (accept) begin
                    case (op.op_code)
                        OP_OPEN: begin
                            if (op.cell_zero) begin
                                nest_d  = WIDTH'(1);
                                state_d = ST_SKIP;
                            end else if (sp_q == SP_FULL) begin
                                ovf_d   = 1'b1;
                                state_d = ST_ERROR;
                            end else begin
                                stk_we = 1'b1;
                                sp_d   = sp_q + (DEPTH+1)'(1);
                            end
                        end
                        OP_CLOSE: begin
                            if (sp_q == '0) begin
                                unf_d   = 1'b1;
                                state_d = ST_ERROR;
                            end else if (op.cell_zero) begin
                                sp_d = sp_q - (DEPTH+1)'(1);
                            end else begin
                                // Back-edge target is the op after the matching '['.
                                jump_pc_d = stk_rd + WIDTH'(1);
                                state_d   = ST_JUMP;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_SKIP: begin
                if (accept) begin
                    case (op.op_code)
                        OP_OPEN: begin
                            if (nest_q == NEST_MAX) begin
                                ovf_d   = 1'b1;
                                state_d = ST_ERROR;
                            end else begin
                                nest_d = nest_q + WIDTH'(1);
                            end
                        end
                        OP_CLOSE: begin
                            nest_d = nest_q - WIDTH'(1);
                            if (nest_q == WIDTH'(1)) begin
                                state_d = ST_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            ST_JUMP:  state_d = ST_RUN;
            default:  state_d = ST_ERROR;
        endcase

        skip_d = (state_d == ST_ERROR) ? skip_q : (state_d == ST_SKIP);
    end

endmodule

// File: tb/tb_loop_ctrl.sv
// tb/tb_loop_ctrl.sv - scoreboard bench for loop_ctrl
module tb_loop_ctrl;
    import bf_pkg::*;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             resetq;
    logic             jump_valid;
    logic [WIDTH-1:0] jump_pc;
    logic             skip;
    logic [DEPTH-1:0] stk_ra;
    logic [WIDTH-1:0] stk_rd;
    logic             stk_we;
    logic [DEPTH-1:0] stk_wa;
    logic [WIDTH-1:0] stk_wd;
    logic [DEPTH:0]   depth;
    logic             err_overflow;
    logic             err_underflow;

    always #5 clk = ~clk;

    loop_ctrl_if #(.WIDTH(WIDTH)) op_if ();

    loop_ctrl #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk           (clk),
        .resetq        (resetq),
        .op            (op_if),
        .jump_valid    (jump_valid),
        .jump_pc       (jump_pc),
        .skip          (skip),
        .stk_ra        (stk_ra),
        .stk_rd        (stk_rd),
        .stk_we        (stk_we),
        .stk_wa        (stk_wa),
        .stk_wd        (stk_wd),
        .depth         (depth),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow)
    );

    logic [WIDTH-1:0] mem [0:(1<<DEPTH)-1];
    assign stk_rd = mem[stk_ra];
    always @(posedge clk) if (stk_we) mem[stk_wa] <= stk_wd;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [DEPTH-1:0] a;
        logic [WIDTH-1:0] d;
    } wr_t;

    wr_t              wq[$];
    logic [WIDTH-1:0] jq[$];

    always @(negedge clk) begin : monitor
        wr_t              e;
        logic [WIDTH-1:0] j;
        #2;
        if (stk_we === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%0h data=%0h expected none", stk_wa, stk_wd);
            end else begin
                e = wq.pop_front();
                if ({stk_wa, stk_wd} !== e) begin
                    failures++;
                    $display("FAIL stack_write got addr=%0h data=%0h expected addr=%0h data=%0h",
                             stk_wa, stk_wd, e.a, e.d);
                end
            end
        end
        if (jump_valid === 1'b1) begin
            checks++;
            if (jq.size() == 0) begin
                failures++;
                $display("FAIL unexpected_jump got pc=%0h expected none", jump_pc);
            end else begin
                j = jq.pop_front();
                if (jump_pc !== j) begin
                    failures++;
                    $display("FAIL jump_target got=%0h expected=%0h", jump_pc, j);
                end
            end
        end
    end

    task automatic send_op(input logic [1:0] code, input logic [WIDTH-1:0] pc, input logic cz);
        int n;
        @(negedge clk);
        op_if.op_valid  = 1'b1;
        op_if.op_code   = code;
        op_if.op_pc     = pc;
        op_if.cell_zero = cz;
        #1;
        n = 0;
        while (op_if.op_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (n >= 20) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout got op_ready=%0b expected 1 within 20 cycles", op_if.op_ready);
        end
        @(posedge clk);
        #1;
        op_if.op_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        resetq         = 1'b0;
        op_if.op_valid = 1'b0;
        repeat (2) @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic test_reset();
        op_if.op_valid  = 1'b1;
        op_if.op_code   = OP_OPEN;
        op_if.op_pc     = 16'h1234;
        op_if.cell_zero = 1'b0;
        #3;
        checks++;
        if (op_if.op_ready !== 1'b0 || stk_we !== 1'b0) begin
            failures++;
            $display("FAIL reset_ready got ready=%0b we=%0b expected 0 0", op_if.op_ready, stk_we);
        end
        checks++;
        if ({jump_valid, jump_pc, skip, depth, err_overflow, err_underflow} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got jv=%0b jpc=%0h skip=%0b depth=%0d ovf=%0b unf=%0b expected all 0",
                     jump_valid, jump_pc, skip, depth, err_overflow, err_underflow);
        end
        op_if.op_valid = 1'b0;
        @(negedge clk);
        resetq = 1'b1;
    endtask

    task automatic test_nested_loop();
        wq.push_back('{a: 4'd0, d: 16'h0010});
        send_op(OP_OPEN, 16'h0010, 1'b0);
        checks++;
        if (depth !== 5'd1) begin failures++; $display("FAIL nest_depth1 got=%0d expected=1", depth); end
        wq.push_back('{a: 4'd1, d: 16'h0020});
        send_op(OP_OPEN, 16'h0020, 1'b0);
        checks++;
        if (depth !== 5'd2) begin failures++; $display("FAIL nest_depth2 got=%0d expected=2", depth); end
        send_op(OP_CLOSE, 16'h0030, 1'b1);
        checks++;
        if (depth !== 5'd1) begin failures++; $display("FAIL nest_pop got=%0d expected=1", depth); end
        jq.push_back(16'h0011);
        send_op(OP_CLOSE, 16'h0040, 1'b0);
        checks++;
        if (jump_valid !== 1'b1 || jump_pc !== 16'h0011 || op_if.op_ready !== 1'b0) begin
            failures++;
            $display("FAIL nest_jump got jv=%0b pc=%0h ready=%0b expected 1 11 0", jump_valid, jump_pc, op_if.op_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (jump_valid !== 1'b0 || depth !== 5'd1 || op_if.op_ready !== 1'b1) begin
            failures++;
            $display("FAIL nest_after_jump got jv=%0b depth=%0d ready=%0b expected 0 1 1", jump_valid, depth, op_if.op_ready);
        end
    endtask

    task automatic test_skip();
        logic [1:0] codes [4];
        logic [1:0] c;
        codes[0] = OP_OPEN;
        codes[1] = OP_OTHER;
        codes[2] = OP_CLOSE;
        codes[3] = OP_CLOSE;
        apply_reset();
        send_op(OP_OPEN, 16'h0005, 1'b1);
        checks++;
        if (skip !== 1'b1 || depth !== 5'd0) begin
            failures++;
            $display("FAIL skip_enter got skip=%0b depth=%0d expected 1 0", skip, depth);
        end
        for (int i = 0; i < 4; i++) begin
            c = codes[i];
            send_op(c, 16'h0006 + 16'(i), 1'b0);
            checks++;
            if (skip !== (i < 3) || depth !== 5'd0) begin
                failures++;
                $display("FAIL skip_step%0d got skip=%0b depth=%0d expected %0b 0", i, skip, depth, (i < 3));
            end
        end
        wq.push_back('{a: 4'd0, d: 16'h000a});
        send_op(OP_OPEN, 16'h000a, 1'b0);
        checks++;
        if (depth !== 5'd1 || skip !== 1'b0) begin
            failures++;
            $display("FAIL skip_resume got depth=%0d skip=%0b expected 1 0", depth, skip);
        end
    endtask

    task automatic test_overflow();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            wq.push_back('{a: 4'(i), d: 16'h0100 + 16'(i)});
            send_op(OP_OPEN, 16'h0100 + 16'(i), 1'b0);
            checks++;
            if (depth !== 5'(i + 1)) begin
                failures++;
                $display("FAIL ovf_fill%0d got depth=%0d expected=%0d", i, depth, i + 1);
            end
        end
        send_op(OP_OPEN, 16'h0200, 1'b0);
        checks++;
        if (err_overflow !== 1'b1 || op_if.op_ready !== 1'b0 || depth !== 5'd16 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL ovf_flag got ovf=%0b ready=%0b depth=%0d unf=%0b expected 1 0 16 0",
                     err_overflow, op_if.op_ready, depth, err_underflow);
        end
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (err_overflow !== 1'b1 || op_if.op_ready !== 1'b0) begin
            failures++;
            $display("FAIL ovf_hold got ovf=%0b ready=%0b expected 1 0", err_overflow, op_if.op_ready);
        end
    endtask

    task automatic test_underflow();
        apply_reset();
        send_op(OP_CLOSE, 16'h0300, 1'b0);
        checks++;
        if (err_underflow !== 1'b1 || op_if.op_ready !== 1'b0 || err_overflow !== 1'b0 || jump_valid !== 1'b0) begin
            failures++;
            $display("FAIL unf_flag got unf=%0b ready=%0b ovf=%0b jv=%0b expected 1 0 0 0",
                     err_underflow, op_if.op_ready, err_overflow, jump_valid);
        end
    endtask

    task automatic test_reset_midflight();
        apply_reset();
        wq.push_back('{a: 4'd0, d: 16'h0040});
        send_op(OP_OPEN, 16'h0040, 1'b0);
        send_op(OP_CLOSE, 16'h0041, 1'b0);
        resetq = 1'b0;
        #1;
        checks++;
        if (jump_valid !== 1'b0 || jump_pc !== 16'h0 || depth !== 5'd0 || op_if.op_ready !== 1'b0) begin
            failures++;
            $display("FAIL rst_jump got jv=%0b pc=%0h depth=%0d ready=%0b expected 0 0 0 0",
                     jump_valid, jump_pc, depth, op_if.op_ready);
        end
        @(negedge clk);
        resetq = 1'b1;
        wq.push_back('{a: 4'd0, d: 16'h0050});
        send_op(OP_OPEN, 16'h0050, 1'b0);
        send_op(OP_OPEN, 16'h0051, 1'b1);
        send_op(OP_OPEN, 16'h0052, 1'b1);
        send_op(OP_OPEN, 16'h0053, 1'b0);
        checks++;
        if (skip !== 1'b1 || depth !== 5'd1) begin
            failures++;
            $display("FAIL rst_skip_setup got skip=%0b depth=%0d expected 1 1", skip, depth);
        end
        resetq = 1'b0;
        #1;
        checks++;
        if (skip !== 1'b0 || depth !== 5'd0 || err_overflow !== 1'b0 || err_underflow !== 1'b0) begin
            failures++;
            $display("FAIL rst_skip got skip=%0b depth=%0d ovf=%0b unf=%0b expected 0 0 0 0",
                     skip, depth, err_overflow, err_underflow);
        end
        @(negedge clk);
        resetq = 1'b1;
        wq.push_back('{a: 4'd0, d: 16'h0060});
        send_op(OP_OPEN, 16'h0060, 1'b0);
        checks++;
        if (depth !== 5'd1 || skip !== 1'b0) begin
            failures++;
            $display("FAIL rst_resume got depth=%0d skip=%0b expected 1 0", depth, skip);
        end
    endtask

    initial begin
        op_if.op_valid  = 1'b0;
        op_if.op_code   = OP_OTHER;
        op_if.op_pc     = '0;
        op_if.cell_zero = 1'b0;
        resetq = 1'b1;
        #1;
        resetq = 1'b0;
        test_reset();
        test_nested_loop();
        test_skip();
        test_overflow();
        test_underflow();
        test_reset_midflight();
        repeat (3) @(negedge clk);
        #3;
        checks++;
        if (wq.size() != 0 || jq.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got writes_left=%0d jumps_left=%0d expected 0 0", wq.size(), jq.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
